// File: rtl/vec_stream_pkg.sv
// Shared types, default MISR constants and the MISR update step used by the
// vector streaming harness.
package vec_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Widest signature the generic step function supports.
  localparam int MISR_MAX_W = 64;

  localparam logic [29:0] MISR_POLY_DEFAULT = 30'h2000_0003;
  localparam logic [29:0] MISR_SEED_DEFAULT = 30'h0;

  // One MISR clock: shift left, fold the dropped MSB back through the taps,
  // then absorb the new response. Only the low w bits are meaningful.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    w
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    mask = (w >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << w) - MISR_MAX_W'(1));
    nxt  = (sig << 1) ^ (sig[6'(w - 1)] ? poly : '0) ^ data;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; a push into
// a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; count/pointers guarantee stale words are never
  // presented as valid, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/vec_stream_misr.sv
// Streams vectors into a combinational DUT, captures its responses LAT edges
// later, compacts them into a MISR and optionally queues them for readout.
module vec_stream_misr
  import vec_stream_pkg::*;
#(
  parameter int               IN_W      = 50,
  parameter int               OUT_W     = 30,
  parameter int               DEPTH     = 4,
  parameter int               LAT       = 1,
  parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(MISR_POLY_DEFAULT),
  parameter logic [OUT_W-1:0] MISR_SEED = OUT_W'(MISR_SEED_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic             mode,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [IN_W-1:0]  vec_data,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OUT_W-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] signature,
  output logic [15:0]      vec_count
);

  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int IFW = $clog2(LAT + 1);

  state_t           state;
  logic [15:0]      num_vec_q;
  logic             mode_q;
  logic [LAT-1:0]   pipe_v;
  logic [IFW-1:0]   inflight;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_empty;
  logic             credit_ok;
  logic             accept;
  logic             capture;
  logic             start_ok;
  logic [OUT_W-1:0] cap_data;

  // Results already queued plus those still in the pipe may never exceed the
  // FIFO, so a capture always finds room even with the consumer stalled.
  assign credit_ok = mode_q || ((int'(fifo_count) + int'(inflight)) < DEPTH);
  assign vec_ready = (state == RUN) && (vec_count < num_vec_q) && credit_ok;
  assign accept    = vec_valid && vec_ready;
  assign capture   = pipe_v[LAT-1];
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign res_valid = !mode_q && !fifo_empty;

  // The first stage is the DUT itself; extra stages hold each response
  // aligned with its valid bit so back-to-back vectors do not overwrite it.
  if (LAT == 1) begin : g_direct
    assign cap_data = dut_out;
  end else begin : g_delay
    logic [OUT_W-1:0] dly [LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LAT - 1; i++) dly[i] <= '0;
      end else begin
        dly[0] <= dut_out;
        for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
      end
    end
    assign cap_data = dly[LAT-2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_vec_q <= '0;
      mode_q    <= 1'b0;
      vec_count <= '0;
      dut_in    <= '0;
      signature <= '0;
      pipe_v    <= '0;
      inflight  <= '0;
    end else begin
      pipe_v   <= (pipe_v << 1) | LAT'(accept);
      inflight <= inflight + IFW'(accept) - IFW'(capture);

      if (accept) begin
        dut_in    <= vec_data;
        vec_count <= vec_count + 16'd1;
      end

      if (capture) begin
        signature <= OUT_W'(misr_step(MISR_MAX_W'(signature), MISR_MAX_W'(cap_data),
                                      MISR_MAX_W'(MISR_POLY), OUT_W));
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_vec_q <= num_vec;
            mode_q    <= mode;
            signature <= MISR_SEED;
            vec_count <= '0;
            state     <= (num_vec == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept && (vec_count + 16'd1 == num_vec_q)) state <= DRAIN;
        end
        DRAIN: begin
          if ((inflight == '0) && (mode_q || fifo_empty)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start_ok),
    .push  (capture && !mode_q),
    .wdata (cap_data),
    .pop   (res_valid && res_ready),
    .rdata (res_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_vec_stream_misr.sv
// Directed bench: two harness instances (LAT=1 and LAT=3) with an identity
// DUT, 8-bit MISR with taps 8'h1D and a zero seed.
module tb_vec_stream_misr;

  logic        clk = 1'b0;
  logic        rst1_n = 1'b0;
  logic        rst3_n = 1'b0;
  logic        use3 = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic        mode = 1'b0;
  logic        vec_valid = 1'b0;
  logic [7:0]  vec_data = '0;
  logic        res_ready = 1'b0;

  logic        vr1, rv1, busy1, done1, vr3, rv3, busy3, done3;
  logic [7:0]  di1, rd1, sig1, di3, rd3, sig3;
  logic [15:0] vc1, vc3;

  logic        o_ready, o_res_valid, o_busy, o_done;
  logic [7:0]  o_dut_in, o_res_data, o_sig;
  logic [15:0] o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign o_ready     = use3 ? vr3   : vr1;
  assign o_res_valid = use3 ? rv3   : rv1;
  assign o_busy      = use3 ? busy3 : busy1;
  assign o_done      = use3 ? done3 : done1;
  assign o_dut_in    = use3 ? di3   : di1;
  assign o_res_data  = use3 ? rd3   : rd1;
  assign o_sig       = use3 ? sig3  : sig1;
  assign o_count     = use3 ? vc3   : vc1;

  vec_stream_misr #(
    .IN_W(8), .OUT_W(8), .DEPTH(4), .LAT(1), .MISR_POLY(8'h1D), .MISR_SEED(8'h00)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .start(start), .num_vec(num_vec), .mode(mode),
    .vec_valid(vec_valid), .vec_ready(vr1), .vec_data(vec_data),
    .dut_in(di1), .dut_out(di1),
    .res_valid(rv1), .res_ready(res_ready), .res_data(rd1),
    .busy(busy1), .done(done1), .signature(sig1), .vec_count(vc1)
  );

  vec_stream_misr #(
    .IN_W(8), .OUT_W(8), .DEPTH(4), .LAT(3), .MISR_POLY(8'h1D), .MISR_SEED(8'h00)
  ) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .start(start), .num_vec(num_vec), .mode(mode),
    .vec_valid(vec_valid), .vec_ready(vr3), .vec_data(vec_data),
    .dut_in(di3), .dut_out(di3),
    .res_valid(rv3), .res_ready(res_ready), .res_data(rd3),
    .busy(busy3), .done(done3), .signature(sig3), .vec_count(vc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] nv, input logic m);
    start   = 1'b1;
    num_vec = nv;
    mode    = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one vector and return on the negedge after it was accepted.
  task automatic drive_vec(input string tag, input logic [7:0] d);
    int n = 0;
    vec_valid = 1'b1;
    vec_data  = d;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({tag, "_accept_timeout"}, 32'(o_ready), 32'd1);
    @(negedge clk);
    vec_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(o_done), 32'd1);
  endtask

  logic [7:0] got [$];
  logic [7:0] exp3 [6];

  initial begin
    exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state
    #12;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_sig", 32'(o_sig), 32'h00);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_dut_in", 32'(o_dut_in), 32'h00);
    check("rst_res_valid", 32'(o_res_valid), 32'd0);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);

    // 1: mode 1, vectors 01,02 -> 01 then 00
    start_run(16'd2, 1'b1);
    check("s1_busy", 32'(o_busy), 32'd1);
    drive_vec("s1_v0", 8'h01);
    check("s1_sig_seed", 32'(o_sig), 32'h00);
    check("s1_dut_in", 32'(o_dut_in), 32'h01);
    drive_vec("s1_v1", 8'h02);
    check("s1_sig_a", 32'(o_sig), 32'h01);
    @(negedge clk);
    check("s1_sig_b", 32'(o_sig), 32'h00);
    wait_done("s1");
    check("s1_count", 32'(o_count), 32'd2);
    check("s1_res_valid", 32'(o_res_valid), 32'd0);
    check("s1_busy_end", 32'(o_busy), 32'd0);

    // 2: rerun from DONE, vectors 80,00 -> 80 then 1D
    start_run(16'd2, 1'b1);
    check("s2_busy", 32'(o_busy), 32'd1);
    check("s2_done_low", 32'(o_done), 32'd0);
    drive_vec("s2_v0", 8'h80);
    drive_vec("s2_v1", 8'h00);
    check("s2_sig_a", 32'(o_sig), 32'h80);
    check("s2_busy_drain", 32'(o_busy), 32'd1);
    @(negedge clk);
    check("s2_sig_b", 32'(o_sig), 32'h1D);
    wait_done("s2");
    check("s2_busy_end", 32'(o_busy), 32'd0);

    // 3: mode 0, six vectors, consumer stalled until the credits run out
    res_ready = 1'b0;
    start_run(16'd6, 1'b0);
    drive_vec("s3_v0", 8'h11);
    drive_vec("s3_v1", 8'h22);
    drive_vec("s3_v2", 8'h33);
    drive_vec("s3_v3", 8'h44);
    check("s3_ready_drop", 32'(o_ready), 32'd0);
    @(negedge clk);
    check("s3_ready_full", 32'(o_ready), 32'd0);
    check("s3_count4", 32'(o_count), 32'd4);
    check("s3_res_valid", 32'(o_res_valid), 32'd1);
    check("s3_head", 32'(o_res_data), 32'h11);
    @(negedge clk);
    check("s3_head_stable", 32'(o_res_data), 32'h11);
    check("s3_busy", 32'(o_busy), 32'd1);
    res_ready = 1'b1;
    vec_valid = 1'b1;
    vec_data  = 8'h55;
    begin
      int nacc = 0;
      logic acc;
      for (int n = 0; n < 60 && !o_done; n++) begin
        if (o_res_valid) got.push_back(o_res_data);
        acc = vec_valid && o_ready;
        @(negedge clk);
        if (acc) begin
          nacc++;
          if (nacc == 1) vec_data = 8'h66;
          else vec_valid = 1'b0;
        end
      end
    end
    res_ready = 1'b0;
    check("s3_done", 32'(o_done), 32'd1);
    check("s3_npop", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) check($sformatf("s3_pop%0d", i), 32'(got[i]), 32'(exp3[i]));
    end
    check("s3_empty", 32'(o_res_valid), 32'd0);
    check("s3_count6", 32'(o_count), 32'd6);
    check("s3_sig", 32'(o_sig), 32'h44);

    // 4: empty run goes straight to DONE with the seed
    start_run(16'd0, 1'b1);
    check("s4_done", 32'(o_done), 32'd1);
    check("s4_sig", 32'(o_sig), 32'h00);
    check("s4_count", 32'(o_count), 32'd0);
    check("s4_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    check("s4_ready_b", 32'(o_ready), 32'd0);
    check("s4_done_hold", 32'(o_done), 32'd1);

    // 5: LAT=3 instance, async reset with two results in flight
    rst1_n = 1'b0;
    use3   = 1'b1;
    rst3_n = 1'b1;
    @(negedge clk);
    start_run(16'd2, 1'b1);
    drive_vec("s5_v0", 8'h01);
    drive_vec("s5_v1", 8'h02);
    check("s5_pre_sig", 32'(o_sig), 32'h00);
    check("s5_pre_busy", 32'(o_busy), 32'd1);
    rst3_n = 1'b0;
    #1;
    check("s5_rst_busy", 32'(o_busy), 32'd0);
    check("s5_rst_done", 32'(o_done), 32'd0);
    check("s5_rst_count", 32'(o_count), 32'd0);
    check("s5_rst_dut_in", 32'(o_dut_in), 32'h00);
    check("s5_rst_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    repeat (3) @(negedge clk);
    check("s5_discard", 32'(o_sig), 32'h00);
    check("s5_idle", 32'(o_busy), 32'd0);
    start_run(16'd2, 1'b1);
    drive_vec("s5_v2", 8'h01);
    drive_vec("s5_v3", 8'h02);
    check("s5_lat_hold", 32'(o_sig), 32'h00);
    @(negedge clk);
    @(negedge clk);
    check("s5_sig_a", 32'(o_sig), 32'h01);
    @(negedge clk);
    check("s5_sig_b", 32'(o_sig), 32'h00);
    wait_done("s5");
    check("s5_count", 32'(o_count), 32'd2);

    // 6: start while busy is ignored; start in DONE reseeds
    rst3_n = 1'b0;
    use3   = 1'b0;
    rst1_n = 1'b1;
    @(negedge clk);
    start_run(16'd2, 1'b1);
    drive_vec("s6_v0", 8'h80);
    start   = 1'b1;
    num_vec = 16'd5;
    drive_vec("s6_v1", 8'h00);
    start = 1'b0;
    wait_done("s6");
    check("s6_count", 32'(o_count), 32'd2);
    check("s6_sig", 32'(o_sig), 32'h1D);
    start_run(16'd1, 1'b1);
    check("s6_reseed", 32'(o_sig), 32'h00);
    check("s6_rerun_busy", 32'(o_busy), 32'd1);
    drive_vec("s6_v2", 8'h07);
    @(negedge clk);
    check("s6_sig_new", 32'(o_sig), 32'h07);
    wait_done("s6b");
    check("s6_count_new", 32'(o_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
